pointer_collision_tracker: RTL and testbench
============================================

Name: pointer_collision_tracker

Overview:
- Sits directly downstream of the obstacle drawing stages and consumes their per-pixel obstacle_x/obstacle_y reports.
- Compares each reported obstacle pixel against the mouse-pointer hit box.
- Keeps the player's life count, applies a post-hit invulnerability window counted in frames, and flags game over to the game-control logic.

Parameters:
CURSOR_W, 16, pointer hit-box width in pixels
CURSOR_H, 16, pointer hit-box height in pixels
LIVES_INIT, 3, lives loaded on reset/restart/IDLE (1..7)
GRACE_FRAMES, 60, frames of invulnerability after a hit (1..255)

Ports:
clk  input  1  system clock (pixel clock domain)
rst_n  input  1  synchronous reset, active low
hcount_in  input  12  current horizontal pixel counter
vcount_in  input  12  current vertical line counter
obstacle_x  input  12  obstacle pixel x; zero when no obstacle pixel this cycle
obstacle_y  input  12  obstacle pixel y; zero when no obstacle pixel this cycle
mouse_xpos  input  12  pointer top-left x
mouse_ypos  input  12  pointer top-left y
game_on  input  1  level, high while a game round is running
restart  input  1  one-cycle pulse, reload lives and return to IDLE
lives  output  3  remaining lives
hit  output  1  one-cycle pulse when a life is taken
invulnerable  output  1  high during grace window
game_over  output  1  high while lives are exhausted

Behaviour:
- Reset: rst_n sampled on the clk rising edge only. Reset values: state IDLE, lives=LIVES_INIT, hit=0, invulnerable=0, game_over=0, frame flag=0, grace counter=0, latched mouse=0.
- Outputs are all registered.
- frame_start is high in the cycle where hcount_in==0 and vcount_in==0.
- Mouse latch: mouse_xpos/mouse_ypos are latched on frame_start and held for the whole frame, so the hit box cannot tear mid-frame.
- Pixel match (combinational, registered into a frame flag):
  - Obstacle pixel is valid when (obstacle_x!=0 || obstacle_y!=0).
  - Match requires a valid pixel AND mx<=obstacle_x<=mx+CURSOR_W-1 AND my<=obstacle_y<=my+CURSOR_H-1.
  - Sums use 13-bit arithmetic, so no wrap near 4095.
- Frame flag: set on any match. On frame_start, the flag OR the current-cycle match is evaluated, then the flag clears. A match coinciding with frame_start belongs to the ending frame.
- FSM states: IDLE, ARMED, GRACE, GAME_OVER.
  - IDLE:
    - lives held at LIVES_INIT; outputs low.
    - game_on=1 -> ARMED next cycle.
    - Frame flag is cleared while in IDLE.
  - ARMED:
    - On frame_start with collision: hit=1 for exactly that one cycle; lives decrements.
    - If lives was 1, go to GAME_OVER (lives=0).
    - Otherwise go to GRACE with the grace counter loaded to GRACE_FRAMES.
  - GRACE:
    - invulnerable=1; collisions are ignored and the frame flag is discarded.
    - Each frame_start decrements the counter.
    - On the frame_start where the counter goes 1->0, move to ARMED. That frame is not evaluated.
  - GAME_OVER:
    - game_over=1, lives=0, hit=0.
    - game_on is ignored; only restart exits (-> IDLE).
- Priority, highest first: !rst_n > restart (any state -> IDLE, lives=LIVES_INIT) > game_on==0 (ARMED/GRACE -> IDLE, lives reload) > frame_start evaluation.
- Lives never underflow: a decrement from 0 is impossible by construction and must be asserted in simulation.
- Latency: collision-pixel to hit pulse is bounded by the next frame_start plus 1 cycle.

Test Plan:
- Reset with rst_n=0 for 3 cycles, then game_on=1 -> lives=3, state ARMED one cycle after game_on, all flags 0.
- Mouse (400,400); inject obstacle (405,410) mid-frame -> at next frame_start, hit pulses for exactly 1 cycle, lives=2, invulnerable=1.
- During grace, inject obstacle (405,410) in every frame -> lives stays 2. After exactly 60 frame_starts, invulnerable=0.
- Boundary: obstacle (415,415) with mouse (400,400) -> hit. Obstacle (416,400) -> no hit. obstacle_x=obstacle_y=0 -> ignored.
- Three separated hits -> lives 3->2->1->0, game_over=1. Dropping game_on leaves it at 1. restart pulse -> IDLE, lives=3, game_over=0.
- Mid-GRACE game_on=0 -> IDLE next cycle, lives=3, invulnerable=0. Separately, rst_n=0 mid-frame with frame flag set -> no hit pulse afterwards.

Source files
------------

// File: rtl/pointer_collision_tracker.sv
// Pointer-vs-obstacle collision tracker: per-frame hit detection, life count,
// post-hit invulnerability window and game-over flag.
module pointer_collision_tracker #(
    parameter int CURSOR_W     = 16,
    parameter int CURSOR_H     = 16,
    parameter int LIVES_INIT   = 3,
    parameter int GRACE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic [11:0] obstacle_x,
    input  logic [11:0] obstacle_y,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        game_on,
    input  logic        restart,
    output logic [2:0]  lives,
    output logic        hit,
    output logic        invulnerable,
    output logic        game_over
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_GRACE     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam logic [2:0]  LIVES_RELOAD = 3'(LIVES_INIT);
    localparam logic [7:0]  GRACE_RELOAD = 8'(GRACE_FRAMES);
    localparam logic [12:0] BOX_W_M1     = 13'(CURSOR_W - 1);
    localparam logic [12:0] BOX_H_M1     = 13'(CURSOR_H - 1);

    state_t      state_q, state_d;
    logic [2:0]  lives_q, lives_d;
    logic        hit_q, hit_d;
    logic        inv_q, inv_d;
    logic        go_q, go_d;
    logic        flag_q, flag_d;
    logic [7:0]  grace_q, grace_d;
    logic [11:0] mx_q, mx_d;
    logic [11:0] my_q, my_d;

    logic        frame_start_s;
    logic        pix_valid_s;
    logic        match_s;
    logic        collide_s;
    logic        dec_s;

    // Frame boundary, pixel validity and hit-box match against the latched pointer
    always_comb begin
        frame_start_s = (hcount_in == 12'd0) && (vcount_in == 12'd0);
        pix_valid_s   = (obstacle_x != 12'd0) || (obstacle_y != 12'd0);
        // 13-bit compare so the box edge cannot wrap past 4095
        match_s       = pix_valid_s
                     && ({1'b0, obstacle_x} >= {1'b0, mx_q})
                     && ({1'b0, obstacle_x} <= ({1'b0, mx_q} + BOX_W_M1))
                     && ({1'b0, obstacle_y} >= {1'b0, my_q})
                     && ({1'b0, obstacle_y} <= ({1'b0, my_q} + BOX_H_M1));
        collide_s     = flag_q | match_s;
    end

    // Next-state, life counter, grace counter and registered-output decode
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        grace_d = grace_q;
        flag_d  = 1'b0;
        hit_d   = 1'b0;
        dec_s   = 1'b0;
        if (frame_start_s) begin
            mx_d = mouse_xpos;
            my_d = mouse_ypos;
        end else begin
            mx_d = mx_q;
            my_d = my_q;
        end

        if (restart) begin
            state_d = ST_IDLE;
            lives_d = LIVES_RELOAD;
            grace_d = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    lives_d = LIVES_RELOAD;
                    grace_d = 8'd0;
                    if (game_on) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (!game_on) begin
                        state_d = ST_IDLE;
                        lives_d = LIVES_RELOAD;
                    end else if (frame_start_s) begin
                        // A match on the frame_start cycle still counts for the ending frame
                        if (collide_s) begin
                            hit_d   = 1'b1;
                            dec_s   = 1'b1;
                            lives_d = lives_q - 3'd1;
                            if (lives_q <= 3'd1) begin
                                state_d = ST_GAME_OVER;
                                grace_d = 8'd0;
                            end else begin
                                state_d = ST_GRACE;
                                grace_d = GRACE_RELOAD;
                            end
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end else begin
                        flag_d = collide_s;
                    end
                end
                ST_GRACE: begin
                    if (!game_on) begin
                        state_d = ST_IDLE;
                        lives_d = LIVES_RELOAD;
                        grace_d = 8'd0;
                    end else if (frame_start_s) begin
                        if (grace_q <= 8'd1) begin
                            state_d = ST_ARMED;
                            grace_d = 8'd0;
                        end else begin
                            state_d = ST_GRACE;
                            grace_d = grace_q - 8'd1;
                        end
                    end else begin
                        state_d = ST_GRACE;
                    end
                end
                ST_GAME_OVER: begin
                    state_d = ST_GAME_OVER;
                    lives_d = 3'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                    lives_d = LIVES_RELOAD;
                    grace_d = 8'd0;
                end
            endcase
        end

        inv_d = (state_d == ST_GRACE);
        go_d  = (state_d == ST_GAME_OVER);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lives_q <= LIVES_RELOAD;
            hit_q   <= 1'b0;
            inv_q   <= 1'b0;
            go_q    <= 1'b0;
            flag_q  <= 1'b0;
            grace_q <= 8'd0;
            mx_q    <= 12'd0;
            my_q    <= 12'd0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            hit_q   <= hit_d;
            inv_q   <= inv_d;
            go_q    <= go_d;
            flag_q  <= flag_d;
            grace_q <= grace_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
        end
    end

    assign lives        = lives_q;
    assign hit          = hit_q;
    assign invulnerable = inv_q;
    assign game_over    = go_q;

    pointer_collision_tracker_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .dec_i   (dec_s),
        .lives_i (lives_q)
    );

endmodule

// Simulation checker: a life may only be taken while at least one remains.
module pointer_collision_tracker_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       dec_i,
    input logic [2:0] lives_i
);

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) dec_i |-> (lives_i != 3'd0));

endmodule

// File: tb/tb_pointer_collision_tracker.sv
// Directed bench for pointer_collision_tracker: vector table for the first hit,
// hand-written sequences for grace expiry, boundaries, game over and resets.
module tb_pointer_collision_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] hcount_in, vcount_in, obstacle_x, obstacle_y, mouse_xpos, mouse_ypos;
    logic        game_on, restart;
    logic [2:0]  lives;
    logic        hit, invulnerable, game_over;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pointer_collision_tracker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .obstacle_x   (obstacle_x),
        .obstacle_y   (obstacle_y),
        .mouse_xpos   (mouse_xpos),
        .mouse_ypos   (mouse_ypos),
        .game_on      (game_on),
        .restart      (restart),
        .lives        (lives),
        .hit          (hit),
        .invulnerable (invulnerable),
        .game_over    (game_over)
    );

    typedef struct {
        logic        rst_n;
        logic [11:0] hc, vc, ox, oy, mx, my;
        logic        gon, rs;
        logic [2:0]  el;
        logic        eh, ei, eg;
    } vec_t;

    vec_t vecs [0:8];

    task automatic check(input string name, input logic [2:0] el, input logic eh, ei, eg);
        checks++;
        if ({lives, hit, invulnerable, game_over} !== {el, eh, ei, eg}) begin
            errors++;
            $display("FAIL %s: got lives=%0d hit=%0b inv=%0b go=%0b, expected lives=%0d hit=%0b inv=%0b go=%0b",
                     name, lives, hit, invulnerable, game_over, el, eh, ei, eg);
        end
    endtask

    task automatic step(input string name, input logic [2:0] el, input logic eh, ei, eg);
        @(posedge clk);
        #1;
        check(name, el, eh, ei, eg);
    endtask

    // One short frame: a mid-frame cycle carrying the obstacle, then the frame_start cycle.
    task automatic do_frame(input logic [11:0] ox, oy, input logic [2:0] el, input logic eh, ei, eg,
                            input string name);
        hcount_in = 12'd7; vcount_in = 12'd3; obstacle_x = ox; obstacle_y = oy;
        @(posedge clk);
        #1;
        hcount_in = 12'd0; vcount_in = 12'd0; obstacle_x = 12'd0; obstacle_y = 12'd0;
        @(posedge clk);
        #1;
        check(name, el, eh, ei, eg);
        hcount_in = 12'd2; vcount_in = 12'd5;
    endtask

    task automatic grace_out(input logic [2:0] el);
        for (int i = 1; i <= 60; i++) begin
            do_frame(12'd405, 12'd410, el, 1'b0, (i < 60), 1'b0, "grace_frame");
        end
    endtask

    initial begin
        //             rst   hc      vc     ox       oy       mx       my       gon   rs    el    eh    ei    eg
        vecs[0] = '{1'b0, 12'd5, 12'd1, 12'd0,   12'd0,   12'd400, 12'd400, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 12'd5, 12'd1, 12'd0,   12'd0,   12'd400, 12'd400, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 12'd5, 12'd1, 12'd0,   12'd0,   12'd400, 12'd400, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 12'd0, 12'd0, 12'd0,   12'd0,   12'd400, 12'd400, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 12'd5, 12'd1, 12'd405, 12'd410, 12'd400, 12'd400, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 12'd6, 12'd1, 12'd0,   12'd0,   12'd400, 12'd400, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 12'd0, 12'd0, 12'd0,   12'd0,   12'd400, 12'd400, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 12'd1, 12'd0, 12'd0,   12'd0,   12'd400, 12'd400, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 12'd3, 12'd2, 12'd405, 12'd410, 12'd400, 12'd400, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 9; i++) begin
            rst_n = vecs[i].rst_n; hcount_in = vecs[i].hc; vcount_in = vecs[i].vc;
            obstacle_x = vecs[i].ox; obstacle_y = vecs[i].oy;
            mouse_xpos = vecs[i].mx; mouse_ypos = vecs[i].my;
            game_on = vecs[i].gon; restart = vecs[i].rs;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].el, vecs[i].eh, vecs[i].ei, vecs[i].eg);
        end

        // Grace window: obstacles every frame are ignored, exits after 60 frame_starts
        grace_out(3'd2);
        do_frame(12'd0, 12'd0, 3'd2, 1'b0, 1'b0, 1'b0, "armed_quiet");

        // Hit-box boundaries against mouse (400,400)
        do_frame(12'd416, 12'd400, 3'd2, 1'b0, 1'b0, 1'b0, "edge_x_out");
        do_frame(12'd400, 12'd416, 3'd2, 1'b0, 1'b0, 1'b0, "edge_y_out");
        do_frame(12'd399, 12'd400, 3'd2, 1'b0, 1'b0, 1'b0, "edge_left_out");
        mouse_xpos = 12'd0; mouse_ypos = 12'd0;
        do_frame(12'd0, 12'd0, 3'd2, 1'b0, 1'b0, 1'b0, "latch_origin");
        do_frame(12'd0, 12'd0, 3'd2, 1'b0, 1'b0, 1'b0, "zero_pixel_ignored");
        mouse_xpos = 12'd400; mouse_ypos = 12'd400;
        do_frame(12'd0, 12'd0, 3'd2, 1'b0, 1'b0, 1'b0, "relatch_400");
        // Mid-frame pointer move must not affect the current frame's box
        mouse_xpos = 12'd1000; mouse_ypos = 12'd1000;
        do_frame(12'd415, 12'd415, 3'd1, 1'b1, 1'b1, 1'b0, "corner_in_hit");
        mouse_xpos = 12'd400; mouse_ypos = 12'd400;
        step("hit_pulse_one", 3'd1, 1'b0, 1'b1, 1'b0);

        // Drop game_on mid-grace
        game_on = 1'b0;
        step("grace_drop", 3'd3, 1'b0, 1'b0, 1'b0);
        game_on = 1'b1;
        step("rearm", 3'd3, 1'b0, 1'b0, 1'b0);
        do_frame(12'd0, 12'd0, 3'd3, 1'b0, 1'b0, 1'b0, "relatch_after_rearm");

        // Three separated hits down to game over
        do_frame(12'd405, 12'd410, 3'd2, 1'b1, 1'b1, 1'b0, "hit1");
        grace_out(3'd2);
        do_frame(12'd405, 12'd410, 3'd1, 1'b1, 1'b1, 1'b0, "hit2");
        grace_out(3'd1);
        do_frame(12'd405, 12'd410, 3'd0, 1'b1, 1'b0, 1'b1, "hit3_game_over");
        step("go_hold", 3'd0, 1'b0, 1'b0, 1'b1);
        game_on = 1'b0;
        step("go_game_on_low", 3'd0, 1'b0, 1'b0, 1'b1);
        game_on = 1'b1;
        do_frame(12'd405, 12'd410, 3'd0, 1'b0, 1'b0, 1'b1, "go_ignores_hits");
        restart = 1'b1;
        step("restart", 3'd3, 1'b0, 1'b0, 1'b0);
        restart = 1'b0;
        step("after_restart", 3'd3, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame with the frame flag set: no hit afterwards
        hcount_in = 12'd9; vcount_in = 12'd4; obstacle_x = 12'd405; obstacle_y = 12'd410;
        step("flag_set", 3'd3, 1'b0, 1'b0, 1'b0);
        obstacle_x = 12'd0; obstacle_y = 12'd0; rst_n = 1'b0;
        step("mid_reset", 3'd3, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step("post_reset", 3'd3, 1'b0, 1'b0, 1'b0);
        hcount_in = 12'd0; vcount_in = 12'd0;
        step("rst_flag_gone", 3'd3, 1'b0, 1'b0, 1'b0);
        hcount_in = 12'd1;
        step("rst_flag_gone2", 3'd3, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
